// File: rtl/dma_pkg.sv
// Shared definitions for the DMA priority arbiter: FSM state encoding and default channel count.
package dma_pkg;

    localparam int NCH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bundle between DMA requesters, the arbiter and the shared timing control.
interface dma_priority_arbiter_if
    import dma_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT
);
    logic [NCH-1:0]         DREQ;
    logic [NCH-1:0]         MASK;
    logic                   ROTATE;
    logic                   HLDA;
    logic                   dack_in;
    logic                   svc_done;
    logic                   grant_valid;
    logic [$clog2(NCH)-1:0] grant_ch;
    logic [NCH-1:0]         DACK;
    logic                   busy;

    modport master (
        input  DREQ, MASK, ROTATE, HLDA, dack_in, svc_done,
        output grant_valid, grant_ch, DACK, busy
    );

    modport slave (
        output DREQ, MASK, ROTATE, HLDA, dack_in, svc_done,
        input  grant_valid, grant_ch, DACK, busy
    );

endinterface

// File: rtl/dma_prio_encoder.sv
// Circular priority search: first set request bit at or after i_start, wrapping NCH-1 -> 0.
module dma_prio_encoder
    import dma_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT
)
(
    input  logic [NCH-1:0]         i_req,
    input  logic [$clog2(NCH)-1:0] i_start,
    output logic [$clog2(NCH)-1:0] o_idx,
    output logic                   o_valid
);
    localparam int W = $clog2(NCH);

    // Scan from lowest to highest priority so the highest-priority hit is assigned last.
    always_comb begin
        int ch;
        ch      = 0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            ch = (int'(i_start) + k) % NCH;
            if (i_req[ch]) begin
                o_idx   = W'(ch);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: IDLE/GRANT/RELEASE FSM with fixed or rotating priority.
// Rotating priority and the last-served register exist only when DMA_ARB_ROTATE_EN is defined.
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT
)
(
    input  logic                  CLK,
    input  logic                  RESET,
    dma_priority_arbiter_if.master bus
);
    localparam int W = $clog2(NCH);

    arb_state_t     r_state;
    arb_state_t     w_state_next;
    logic           r_grant_valid;
    logic           w_grant_valid_next;
    logic [W-1:0]   r_grant_ch;
    logic [W-1:0]   w_grant_ch_next;
    logic           r_busy;
    logic [NCH-1:0] w_req;
    logic [W-1:0]   w_start;
    logic [W-1:0]   w_win;
    logic           w_win_valid;
    logic [NCH-1:0] w_dack;

    assign w_req = bus.DREQ & ~bus.MASK;

`ifdef DMA_ARB_ROTATE_EN
    logic [W-1:0] r_last_ch;

    assign w_start = !bus.ROTATE                ? '0 :
                     (r_last_ch == W'(NCH - 1)) ? '0 :
                                                  r_last_ch + 1'b1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last_ch <= W'(NCH - 1);
        end else if (r_state == ST_GRANT && bus.svc_done) begin
            r_last_ch <= r_grant_ch;
        end
    end
`else
    logic w_unused_rotate;

    assign w_unused_rotate = bus.ROTATE;
    assign w_start         = '0;
`endif

    dma_prio_encoder #(.NCH(NCH)) u_prio (
        .i_req   (w_req),
        .i_start (w_start),
        .o_idx   (w_win),
        .o_valid (w_win_valid)
    );

    // Completion is checked before cancel so a finished service always passes through RELEASE.
    always_comb begin
        w_state_next       = r_state;
        w_grant_valid_next = r_grant_valid;
        w_grant_ch_next    = r_grant_ch;
        unique case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_state_next       = ST_GRANT;
                    w_grant_valid_next = 1'b1;
                    w_grant_ch_next    = w_win;
                end
            end
            ST_GRANT: begin
                if (bus.svc_done) begin
                    w_state_next       = ST_RELEASE;
                    w_grant_valid_next = 1'b0;
                end else if (!bus.HLDA && !bus.DREQ[r_grant_ch]) begin
                    w_state_next       = ST_IDLE;
                    w_grant_valid_next = 1'b0;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next       = ST_IDLE;
                w_grant_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_grant_ch    <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_grant_valid <= w_grant_valid_next;
            r_grant_ch    <= w_grant_ch_next;
            r_busy        <= (w_state_next != ST_IDLE);
        end
    end

    always_comb begin
        w_dack = '0;
        if (bus.dack_in && r_grant_valid) begin
            w_dack[r_grant_ch] = 1'b1;
        end
    end

    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_ch    = r_grant_ch;
    assign bus.busy        = r_busy;
    assign bus.DACK        = w_dack;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter (4 channels); rotating expectations follow DMA_ARB_ROTATE_EN.
module tb_dma_priority_arbiter;
    import dma_pkg::*;

    localparam int NCH = 4;
`ifdef DMA_ARB_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    dma_priority_arbiter_if #(.NCH(NCH)) bus ();

    dma_priority_arbiter #(.NCH(NCH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.DREQ     = '0;
        bus.MASK     = '0;
        bus.ROTATE   = 1'b0;
        bus.HLDA     = 1'b0;
        bus.dack_in  = 1'b0;
        bus.svc_done = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        clear_inputs();
        step();
        step();
        RESET = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_gv: got %0b want 0", bus.grant_valid); end
        checks++; if (bus.grant_ch !== 2'd0) begin errors++; $display("[TB] FAIL reset_ch: got %0d want 0", bus.grant_ch); end
        checks++; if (bus.DACK !== 4'b0000) begin errors++; $display("[TB] FAIL reset_dack: got %b want 0000", bus.DACK); end
    endtask

    task automatic test_fixed();
        bus.DREQ = 4'b1010;
        bus.HLDA = 1'b1;
        #1;
        checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL fixed_latency: got %0b want 0", bus.grant_valid); end
        step();
        checks++; if (bus.grant_valid !== 1'b1) begin errors++; $display("[TB] FAIL fixed_gv: got %0b want 1", bus.grant_valid); end
        checks++; if (bus.grant_ch !== 2'd1) begin errors++; $display("[TB] FAIL fixed_ch: got %0d want 1", bus.grant_ch); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL fixed_busy: got %0b want 1", bus.busy); end
        bus.DREQ = 4'b0011;
        step();
        checks++; if (bus.grant_ch !== 2'd1) begin errors++; $display("[TB] FAIL grant_stable: got %0d want 1", bus.grant_ch); end
        bus.svc_done = 1'b1;
        bus.DREQ     = 4'b0000;
        step();
        bus.svc_done = 1'b0;
        checks++; if (bus.grant_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL release_state: got gv=%0b busy=%0b want gv=0 busy=1", bus.grant_valid, bus.busy); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL release_to_idle: got busy=%0b want 0", bus.busy); end
        bus.svc_done = 1'b1;
        step();
        bus.svc_done = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_svc_ignored: got busy=%0b want 0", bus.busy); end
    endtask

    task automatic test_mask_dack_cancel();
        bus.DREQ = 4'b0110;
        bus.MASK = 4'b0010;
        bus.HLDA = 1'b1;
        step();
        checks++; if (bus.grant_ch !== 2'd2 || bus.grant_valid !== 1'b1) begin errors++; $display("[TB] FAIL mask_ch: got ch=%0d gv=%0b want ch=2 gv=1", bus.grant_ch, bus.grant_valid); end
        bus.dack_in = 1'b1;
        #1;
        checks++; if (bus.DACK !== 4'b0100) begin errors++; $display("[TB] FAIL dack_onehot: got %b want 0100", bus.DACK); end
        bus.MASK = 4'b0100;
        step();
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_ch !== 2'd2) begin errors++; $display("[TB] FAIL mask_no_abort: got gv=%0b ch=%0d want gv=1 ch=2", bus.grant_valid, bus.grant_ch); end
        bus.HLDA = 1'b0;
        bus.DREQ = 4'b0000;
        step();
        checks++; if (bus.grant_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel: got gv=%0b busy=%0b want gv=0 busy=0", bus.grant_valid, bus.busy); end
        checks++; if (bus.DACK !== 4'b0000) begin errors++; $display("[TB] FAIL cancel_dack: got %b want 0000", bus.DACK); end
        clear_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        bus.DREQ = 4'b0001;
        bus.HLDA = 1'b1;
        step();
        checks++; if (bus.grant_ch !== 2'd0 || bus.grant_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got ch=%0d gv=%0b want ch=0 gv=1", bus.grant_ch, bus.grant_valid); end
        bus.svc_done = 1'b1;
        step();
        bus.svc_done = 1'b0;
        checks++; if (bus.grant_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL gap_e1: got gv=%0b busy=%0b want gv=0 busy=1", bus.grant_valid, bus.busy); end
        step();
        checks++; if (bus.grant_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL gap_e2: got gv=%0b busy=%0b want gv=0 busy=0", bus.grant_valid, bus.busy); end
        step();
        checks++; if (bus.grant_valid !== 1'b1 || bus.grant_ch !== 2'd0) begin errors++; $display("[TB] FAIL regrant_e3: got gv=%0b ch=%0d want gv=1 ch=0", bus.grant_valid, bus.grant_ch); end
        bus.HLDA     = 1'b0;
        bus.DREQ     = 4'b0000;
        bus.svc_done = 1'b1;
        step();
        bus.svc_done = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL svc_over_cancel: got busy=%0b gv=%0b want busy=1 gv=0", bus.busy, bus.grant_valid); end
        step();
    endtask

    task automatic test_rotate_and_reset();
        logic [1:0] expCh;
        RESET = 1'b1;
        clear_inputs();
        step();
        RESET       = 1'b0;
        bus.ROTATE  = 1'b1;
        bus.HLDA    = 1'b1;
        bus.DREQ    = 4'b0010;
        step();
        checks++; if (bus.grant_ch !== 2'd1) begin errors++; $display("[TB] FAIL rot_first: got %0d want 1", bus.grant_ch); end
        bus.DREQ     = 4'b1011;
        bus.svc_done = 1'b1;
        step();
        bus.svc_done = 1'b0;
        step();
        step();
        expCh = ROT_EN ? 2'd3 : 2'd0;
        checks++; if (bus.grant_ch !== expCh || bus.grant_valid !== 1'b1) begin errors++; $display("[TB] FAIL rot_second: got ch=%0d gv=%0b want ch=%0d gv=1", bus.grant_ch, bus.grant_valid, expCh); end
        bus.svc_done = 1'b1;
        step();
        bus.svc_done = 1'b0;
        step();
        step();
        checks++; if (bus.grant_ch !== 2'd0 || bus.grant_valid !== 1'b1) begin errors++; $display("[TB] FAIL rot_wrap: got ch=%0d gv=%0b want ch=0 gv=1", bus.grant_ch, bus.grant_valid); end
        bus.svc_done = 1'b1;
        step();
        bus.svc_done = 1'b0;
        bus.DREQ     = 4'b1000;
        step();
        step();
        checks++; if (bus.grant_ch !== 2'd3) begin errors++; $display("[TB] FAIL pre_reset_ch: got %0d want 3", bus.grant_ch); end
        bus.dack_in = 1'b1;
        #1;
        checks++; if (bus.DACK !== 4'b1000) begin errors++; $display("[TB] FAIL pre_reset_dack: got %b want 1000", bus.DACK); end
        RESET = 1'b1;
        step();
        checks++; if (bus.busy !== 1'b0 || bus.grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset: got busy=%0b gv=%0b want 0 0", bus.busy, bus.grant_valid); end
        checks++; if (bus.DACK !== 4'b0000 || bus.grant_ch !== 2'd0) begin errors++; $display("[TB] FAIL mid_reset_out: got dack=%b ch=%0d want 0000 0", bus.DACK, bus.grant_ch); end
        RESET       = 1'b0;
        bus.dack_in = 1'b0;
        bus.DREQ    = 4'b1111;
        step();
        checks++; if (bus.grant_ch !== 2'd0 || bus.grant_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_grant: got ch=%0d gv=%0b want ch=0 gv=1", bus.grant_ch, bus.grant_valid); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_mask_dack_cancel();
        test_back_to_back();
        test_rotate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
